seq_magnitude_comparator: RTL and testbench

Parametrised multi-cycle magnitude comparator for two WIDTH-bit operands, in signed or unsigned mode. It compares CHUNK bits per cycle, MSB-first, and uses a start/busy/done handshake. The gt/eq/lt result is registered and held until the next comparison completes. It is the shared compare engine for wide datapath checks where a full-width single-cycle compare would be the critical path.

---
 rtl/cmp_pkg.sv | 24 ++
 rtl/cmp_chunk.sv | 20 ++
 rtl/seq_magnitude_comparator.sv | 137 +++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
//   state_e : engine FSM states
//   res_e   : encoding of a comparison outcome
//   widths_ok() : elaboration-time legality check for WIDTH/CHUNK
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_GT,
    RES_EQ,
    RES_LT
  } res_e;

  function automatic bit widths_ok(input int unsigned width, input int unsigned chunk);
    return (width >= 2) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one Width-bit chunk.
// Ports:
//   a_i, b_i : chunk operands (unsigned)
//   gt_o     : a_i > b_i
//   lt_o     : a_i < b_i
module cmp_chunk #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o
);

  always_comb begin
    gt_o = (a_i > b_i);
    lt_o = (a_i < b_i);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator. Compares two WIDTH-bit operands CHUNK bits per cycle,
// MSB-first, in signed or unsigned mode, with a start/busy/done handshake.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : request, sampled only when idle
//   signed_mode       : 1 = two's-complement compare; latched with start
//   a, b              : operands; latched with start
//   busy              : operation in progress (COMPARE and DONE states)
//   done              : one-cycle pulse when gt/eq/lt update
//   gt, eq, lt        : registered one-hot result, held until the next done
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!widths_ok(WIDTH, CHUNK)) begin : g_bad_width
    $fatal(1, "seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sb_q;
  logic [CntW-1:0]   cnt_q;
  logic              decided_q;
  res_e              pending_q;
  logic              done_q, gt_q, eq_q, lt_q;

  logic              chunk_gt, chunk_lt;
  logic              last_chunk;
  logic [WIDTH-1:0]  msb_flip;
  res_e              final_res;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_flip   = {signed_mode, {(WIDTH-1){1'b0}}};
  assign last_chunk = (cnt_q == CntW'(NCHUNK - 1));
  assign final_res  = decided_q ? pending_q : RES_EQ;

  cmp_chunk #(
    .Width (CHUNK)
  ) u_cmp_chunk (
    .a_i  (sa_q[WIDTH-1 -: CHUNK]),
    .b_i  (sb_q[WIDTH-1 -: CHUNK]),
    .gt_o (chunk_gt),
    .lt_o (chunk_lt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COMPARE;
      COMPARE: if (last_chunk) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    gt   = gt_q;
    eq   = eq_q;
    lt   = lt_q;
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      pending_q <= RES_NONE;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sa_q      <= a ^ msb_flip;
            sb_q      <= b ^ msb_flip;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            pending_q <= RES_NONE;
          end
        end
        COMPARE: begin
          // The first differing chunk decides; later chunks cannot override it.
          if (!decided_q && (chunk_gt || chunk_lt)) begin
            decided_q <= 1'b1;
            pending_q <= chunk_gt ? RES_GT : RES_LT;
          end
          sa_q  <= sa_q << CHUNK;
          sb_q  <= sb_q << CHUNK;
          cnt_q <= cnt_q + CntW'(1);
        end
        DONE: begin
          done_q <= 1'b1;
          gt_q   <= (final_res == RES_GT);
          eq_q   <= (final_res == RES_EQ);
          lt_q   <= (final_res == RES_LT);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=8, CHUNK=2) using a result scoreboard.
module tb_seq_magnitude_comparator;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CHUNK  = 2;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, gt, eq, lt;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] prev_res = 3'b000;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ordering, {gt, eq, lt}
  function automatic logic [2:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                       input logic s);
    logic g, l;
    if (s) begin
      g = $signed(x) > $signed(y);
      l = $signed(x) < $signed(y);
    end else begin
      g = x > y;
      l = x < y;
    end
    return {g, !g && !l, l};
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("result", 32'({gt, eq, lt}), 32'(exp_q.pop_front()));
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                        input string tag);
    logic [2:0] e;
    int busy_n, lat;
    bit seen;
    e = model(x, y, s);
    exp_q.push_back(e);
    @(negedge clk);
    a = x; b = y; signed_mode = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Changing inputs after acceptance must not affect the result
    a = ~x; b = ~y; signed_mode = ~s;
    busy_n = 0; lat = 0; seen = 1'b0;
    for (int i = 1; i <= 4 * NCHUNK + 8 && !seen; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_n++;
        check({tag, "_hold"}, 32'({gt, eq, lt}), 32'(prev_res));
      end
      if (done) begin
        seen = 1'b1;
        lat = i - 1;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, lat, NCHUNK + 1);
    check({tag, "_busy"}, busy_n, NCHUNK + 1);
    prev_res = e;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_keep"}, 32'({gt, eq, lt}), 32'(e));
  endtask

  initial begin
    int n0;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({busy, done, gt, eq, lt}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", 32'({busy, done, gt, eq, lt}), 32'd0);

    // Basic unsigned, signed and equality cases
    run_op(8'hA5, 8'h5A, 1'b0, "t1");
    run_op(8'h80, 8'h7F, 1'b1, "t2_s");
    run_op(8'h80, 8'h7F, 1'b0, "t2_u");
    run_op(8'hFF, 8'hFE, 1'b1, "t2_neg");
    run_op(8'h3C, 8'h3C, 1'b1, "t3_eq_s");
    run_op(8'h3C, 8'h3C, 1'b0, "t3_eq_u");
    run_op(8'h01, 8'h00, 1'b0, "t3_last");
    run_op(8'h7F, 8'h80, 1'b1, "t4_s");
    run_op(8'h40, 8'h3F, 1'b0, "t4_u");

    // Start during COMPARE is ignored
    n0 = n_done;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    @(negedge clk);
    a = 8'h10; b = 8'h20; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'h30; b = 8'h00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_one_done", n_done - n0, 32'd1);
    check("t5_lt", 32'({gt, eq, lt}), 32'b001);
    prev_res = 3'b001;
    run_op(8'h30, 8'h00, 1'b0, "t5_next");

    // Reset mid-operation
    run_op(8'h3C, 8'h3C, 1'b0, "t6_pre");
    n0 = n_done;
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    check("t6_busy_before", 32'({busy, eq}), 32'b11);
    #2 rst_n = 1'b0;
    #1 check("t6_async_clear", 32'({busy, done, gt, eq, lt}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_no_done", n_done - n0, 32'd0);
    check("t6_still_zero", 32'({busy, done, gt, eq, lt}), 32'd0);
    prev_res = 3'b000;
    run_op(8'h00, 8'hFF, 1'b1, "t6_after");

    // A few random operations
    for (int i = 0; i < 6; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rnd");
    end

    check("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
